gpio_pinmux: RTL and testbench

GPIO_PINMUX -- requirements
Module: gpio_pinmux

---
 rtl/gpio_pinmux.sv | 142 ++++++++++++++
 tb/tb_gpio_pinmux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pinmux.sv
// GPIO pin multiplexer: bus-mapped OUT/OE/ALT_SEL registers, synchronized pad inputs.
// Define GPIO_PINMUX_IRQ_EN to add edge detection, RISE_EN/FALL_EN/PEND and irq.
module gpio_pinmux #(
  parameter int unsigned      NPINS   = 8,
  parameter logic [NPINS-1:0] RST_ALT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  input  logic [NPINS-1:0] periph_out,
  input  logic [NPINS-1:0] periph_oe,
  input  logic [NPINS-1:0] pad_in,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oe,
  output logic             irq
);

  logic [2:0]       sel;
  logic             access, wr, rd;
  logic [NPINS-1:0] wval, rd_val;
  logic             unused_bits;

  logic [NPINS-1:0] out_q, out_d, oe_q, oe_d, alt_q, alt_d;
  logic [NPINS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic             bus_ready_q, bus_ready_d;
  logic [31:0]      bus_rdata_q, bus_rdata_d;

  assign sel         = bus_addr[4:2];
  assign access      = bus_valid & ~bus_ready_q;
  assign wr          = access & bus_we;
  assign rd          = access & ~bus_we;
  assign wval        = bus_wdata[NPINS-1:0];
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  assign pad_out   = (alt_q & periph_out) | (~alt_q & out_q);
  assign pad_oe    = (alt_q & periph_oe)  | (~alt_q & oe_q);
  assign bus_ready = bus_ready_q;
  assign bus_rdata = bus_rdata_q;

`ifdef GPIO_PINMUX_IRQ_EN
  logic [NPINS-1:0] prev_q, prev_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NPINS-1:0] pend_q, pend_d, pend_clr, edge_ev;
  logic             irq_q, irq_d;
  logic [1:0]       guard_q, guard_d;

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    out_d       = out_q;
    oe_d        = oe_q;
    alt_d       = alt_q;
    sync1_d     = pad_in;
    sync2_d     = sync1_q;
    bus_ready_d = access;
    bus_rdata_d = '0;
    rd_val      = '0;
`ifdef GPIO_PINMUX_IRQ_EN
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    // prev follows the synchronizer until it has filled, so reset never fakes an edge
    guard_d   = (guard_q == 2'd2) ? guard_q : guard_q + 2'd1;
    prev_d    = (guard_q < 2'd2) ? sync2_d : sync2_q;
    edge_ev   = ((sync2_q & ~prev_q) & rise_en_q) | ((~sync2_q & prev_q) & fall_en_q);
    irq_d     = |pend_q;
`endif
    if (wr) begin
      case (sel)
        3'd0: out_d = wval;
        3'd1: oe_d  = wval;
        3'd3: alt_d = wval;
`ifdef GPIO_PINMUX_IRQ_EN
        3'd4: rise_en_d = wval;
        3'd5: fall_en_d = wval;
        3'd6: pend_clr  = wval;
`endif
        default: ;
      endcase
    end
`ifdef GPIO_PINMUX_IRQ_EN
    pend_d = (pend_q & ~pend_clr) | edge_ev;
`endif
    case (sel)
      3'd0: rd_val = out_q;
      3'd1: rd_val = oe_q;
      3'd2: rd_val = sync2_q;
      3'd3: rd_val = alt_q;
`ifdef GPIO_PINMUX_IRQ_EN
      3'd4: rd_val = rise_en_q;
      3'd5: rd_val = fall_en_q;
      3'd6: rd_val = pend_q;
`endif
      default: rd_val = '0;
    endcase
    if (rd) bus_rdata_d[NPINS-1:0] = rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      oe_q        <= '0;
      alt_q       <= RST_ALT;
      sync1_q     <= '0;
      sync2_q     <= '0;
      bus_ready_q <= 1'b0;
      bus_rdata_q <= '0;
`ifdef GPIO_PINMUX_IRQ_EN
      prev_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
      guard_q   <= '0;
`endif
    end else begin
      out_q       <= out_d;
      oe_q        <= oe_d;
      alt_q       <= alt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      bus_ready_q <= bus_ready_d;
      bus_rdata_q <= bus_rdata_d;
`ifdef GPIO_PINMUX_IRQ_EN
      prev_q    <= prev_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      guard_q   <= guard_d;
`endif
    end
  end

endmodule

// File: tb/tb_gpio_pinmux.sv
// Self-checking bench for gpio_pinmux (NPINS=8); covers both GPIO_PINMUX_IRQ_EN builds.
module tb_gpio_pinmux;

  logic        clk = 1'b0;
  logic        rst, bus_valid, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready, irq;
  logic [7:0]  periph_out, periph_oe, pad_in, pad_out, pad_oe;

  int total = 0;
  int bad   = 0;

  // reference state: what software should observe
  logic [7:0] m_out, m_oe, m_alt, m_pad;

  gpio_pinmux #(.NPINS(8), .RST_ALT(8'hFF)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .periph_out(periph_out), .periph_oe(periph_oe),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [2:0] sel, input logic [31:0] wd,
                      output logic [31:0] rd);
    bus_valid = 1'b1; bus_we = we; bus_addr = {sel, 2'b00}; bus_wdata = wd;
    @(posedge clk); #1;
    check("ready_hi", 32'(bus_ready), 32'd1);
    rd = bus_rdata;
    bus_valid = 1'b0;
    @(posedge clk); #1;
    check("ready_lo", 32'(bus_ready), 32'd0);
    check("rdata_idle", bus_rdata, 32'd0);
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(1'b1, sel, wd, dummy);
    case (sel)
      3'd0: m_out = wd[7:0];
      3'd1: m_oe  = wd[7:0];
      3'd3: m_alt = wd[7:0];
      default: ;
    endcase
  endtask

  task automatic rd_check(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, sel, 32'd0, r);
    check(tag, r, exp);
  endtask

  task automatic check_pads(input string tag);
    periph_out = 8'($urandom);
    periph_oe  = 8'($urandom);
    #1;
    check({tag, "_out"}, 32'(pad_out), 32'((m_alt & periph_out) | (~m_alt & m_out)));
    check({tag, "_oe"},  32'(pad_oe),  32'((m_alt & periph_oe)  | (~m_alt & m_oe)));
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] sel);
    case (sel)
      3'd0:    return 32'(m_out);
      3'd1:    return 32'(m_oe);
      3'd2:    return 32'(m_pad);
      3'd3:    return 32'(m_alt);
      default: return 32'd0;  // edge regs stay 0 during the random phase in both builds
    endcase
  endfunction

  initial begin
    logic [2:0]  sel;
    logic [31:0] d;

    rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    periph_out = '0; periph_oe = '0; pad_in = '0;
    m_out = '0; m_oe = '0; m_alt = 8'hFF; m_pad = '0;
    idle(3);
    check("rst_ready", 32'(bus_ready), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    rd_check("rst_alt", 3'd3, 32'hFF);
    rd_check("rst_out", 3'd0, 32'h0);
    check_pads("rst_pads");
    check("rst_irq2", 32'(irq), 32'd0);

    wr_reg(3'd3, 32'h0);
    wr_reg(3'd1, 32'h0F);
    wr_reg(3'd0, 32'hA5);
    check_pads("gpio_pads");
    check("pad_oe_0f", 32'(pad_oe), 32'h0F);
    check("pad_out_a5", 32'(pad_out), 32'hA5);
    wr_reg(3'd0, 32'hFFFF_FFFF);
    rd_check("out_mask", 3'd0, 32'hFF);

    // pad change just after an edge: first read lands one edge later, second two edges later
    pad_in = 8'h81;
    rd_check("in_t1", 3'd2, 32'h00);
    rd_check("in_t2", 3'd2, 32'h81);
    m_pad = 8'h81;

    for (int unsigned i = 0; i < 40; i++) begin
      sel = 3'($urandom_range(0, 7));
`ifdef GPIO_PINMUX_IRQ_EN
      if (sel >= 3'd4 && sel <= 3'd6) sel = 3'd7;
`endif
      d = $urandom;
      wr_reg(sel, d);
      pad_in = 8'($urandom);
      idle(3);
      m_pad = pad_in;
      sel = 3'($urandom_range(0, 7));
      rd_check("rand_rd", sel, model_read(sel));
      check_pads("rand_pads");
    end

`ifdef GPIO_PINMUX_IRQ_EN
    pad_in = 8'h80;
    idle(4);
    wr_reg(3'd4, 32'h01);
    wr_reg(3'd5, 32'h80);
    rd_check("pend_clean", 3'd6, 32'h0);
    pad_in = 8'h01;
    idle(3);
    check("irq_not_yet", 32'(irq), 32'd0);
    idle(1);
    check("irq_set", 32'(irq), 32'd1);
    rd_check("pend_81", 3'd6, 32'h81);
    wr_reg(3'd6, 32'h01);
    rd_check("pend_w1c", 3'd6, 32'h80);
    check("irq_stays", 32'(irq), 32'd1);

    wr_reg(3'd6, 32'hFF);
    pad_in = 8'h00;
    idle(4);
    pad_in = 8'h01;
    idle(4);
    rd_check("pend_rise0", 3'd6, 32'h01);
    pad_in = 8'h00;
    idle(4);
    pad_in = 8'h01;
    idle(2);
    wr_reg(3'd6, 32'h01);  // clear lands on the same edge as the new rise
    rd_check("pend_set_wins", 3'd6, 32'h01);
    wr_reg(3'd6, 32'hFF);
    rd_check("pend_clr_all", 3'd6, 32'h0);
    check("irq_clr", 32'(irq), 32'd0);
`else
    wr_reg(3'd4, 32'hFF);
    wr_reg(3'd5, 32'hFF);
    wr_reg(3'd6, 32'hFF);
    for (int unsigned i = 0; i < 6; i++) begin
      pad_in = ~pad_in;
      for (int unsigned c = 0; c < 4; c++) begin
        idle(1);
        check("noirq_irq", 32'(irq), 32'd0);
      end
    end
    rd_check("noirq_rise", 3'd4, 32'h0);
    rd_check("noirq_fall", 3'd5, 32'h0);
    rd_check("noirq_pend", 3'd6, 32'h0);
`endif
    rd_check("reg7_zero", 3'd7, 32'h0);

    // reset during a pending write: no ready, state back to reset values
    pad_in = 8'hFF;
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 5'h00; bus_wdata = 32'h3C;
    rst = 1'b1;
    idle(1);
    check("abort_ready", 32'(bus_ready), 32'd0);
    idle(2);
    bus_valid = 1'b0;
    rst = 1'b0;
    m_out = '0; m_oe = '0; m_alt = 8'hFF;
    wr_reg(3'd4, 32'hFF);  // rise enables live before the synchronizer has filled
    idle(4);
    rd_check("warmup_pend", 3'd6, 32'h0);
    check("warmup_irq", 32'(irq), 32'd0);
    rd_check("abort_out", 3'd0, 32'h0);
    rd_check("abort_alt", 3'd3, 32'hFF);
    rd_check("warmup_in", 3'd2, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
